lsq_param: RTL
==============

LSQ_PARAM -- requirements
Module: lsq_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16: queue entries, power of two, 4..64.
REQ-002 SHALL have parameter ROB_W, default 5: ROB tag width; tag 0 means "no dependency/value ready".
REQ-003 SHALL have parameter DATA_W, default 32: operand, offset and value width.
REQ-004 SHALL have parameter RDY_MARGIN, default 1: free entries reserved for in-flight dispatch.
REQ-005 SHALL have port clk_in  in  1: clock, the only clock; rst_in  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port rdy_in  in  1: global enable; lbuffer_rdy_in  in  1: load buffer can accept.
REQ-007 SHALL have port instqueue_rdy_out  out  1: dispatch may be presented next cycle.
REQ-008 SHALL have ports dispatcher_en_in in 1, dispatcher_vj_in/vk_in in DATA_W, dispatcher_qj_in/qk_in in ROB_W, dispatcher_inst_type_in in `INST_TYPE_WIDTH, dispatcher_A_in in DATA_W, dispatcher_dest_in in ROB_W: new entry.
REQ-009 SHALL have CDB channels cdb_alu_* and cdb_lbuffer_*: en in 1, dest in ROB_W, value in DATA_W.
REQ-010 SHALL have rob_flush_in in 1 and outputs rob_en_out 1, rob_dest_out ROB_W, rob_value_out DATA_W: store-data report.
REQ-011 SHALL have outputs addressUnit_en_out 1, addressUnit_A_out DATA_W, addressUnit_vj_out DATA_W, addressUnit_dest_out ROB_W, addressUnit_inst_type_out `INST_TYPE_WIDTH.
REQ-012 SHALL drive all outputs except instqueue_rdy_out from registers.

Function
REQ-013 SHALL hold a circular FIFO with head, tail (log2 DEPTH bits) and count (log2 DEPTH + 1 bits); all DEPTH entries usable; pointers wrap DEPTH-1 -> 0.
REQ-014 SHALL drive instqueue_rdy_out = (count + RDY_MARGIN <= DEPTH - 1), combinationally.
REQ-015 SHALL write an entry at tail on dispatcher_en_in when count < DEPTH; when count == DEPTH, SHALL ignore the dispatch with no state change.
REQ-016 SHALL, on dispatch, capture any matching same-cycle CDB value for qj/qk and store tag 0 (dispatch bypass).
REQ-017 SHALL, each cycle, compare every valid entry's nonzero qj/qk with both CDB channels; on match, load value and clear tag; cdb_lbuffer takes priority if both match.
REQ-018 SHALL give each store entry (`SB..`SW) a reported flag, cleared on dispatch.
REQ-019 SHALL select the oldest valid store from head with qk == 0 and reported == 0; next cycle rob_en_out=1, rob_dest_out=dest, rob_value_out=vk zero-extended from bits [7:0] (SB), [15:0] (SH) or full (SW); reported set; at most one report per cycle.
REQ-020 SHALL issue the head entry when count > 0 and qj == 0 and either it is a load (`LB..`LHU) with lbuffer_rdy_in=1, or it is a store with reported=1.
REQ-021 SHALL, on issue, register addressUnit_en_out=1 and A, vj, dest, inst_type of the head next cycle, advance head, and decrement count.
REQ-022 SHALL evaluate issue and report from registered entry state; a CDB value therefore enables issue or report one cycle after its broadcast.
REQ-023 SHALL leave count unchanged on simultaneous dispatch and issue; the full check uses pre-issue count.
REQ-024 SHALL pulse rob_en_out and addressUnit_en_out for one cycle per event; default 0 every cycle.
REQ-025 SHALL, when rdy_in=0, hold all state and drive both enables 0.
REQ-026 SHALL, on rob_flush_in=1 with rdy_in=1, invalidate all entries, set head=tail=count=0, drive enables 0, and drop a same-cycle dispatch.

Reset
REQ-027 SHALL, while rst_in=0, immediately force head=tail=count=0, all entries invalid, rob_en_out=0, addressUnit_en_out=0, all data outputs 0; this also aborts a mid-operation issue.
REQ-028 SHALL resume on the first rising clk_in after rst_in deasserts, with instqueue_rdy_out=1.

Verification
REQ-029 SHALL cover load: dispatch LW qj=0 vj=0x100 A=0x8 dest=3, lbuffer_rdy_in=1 -> addressUnit_en_out=1 with vj=0x100, A=0x8, dest=3 two cycles after dispatch.
REQ-030 SHALL cover store: dispatch SB qj=0 qk=7 dest=4; CDB alu dest=7 value=0x1234ABCD -> rob_en_out=1, rob_dest_out=4, rob_value_out=0xCD; address issue follows the next cycle.
REQ-031 SHALL cover bypass: dispatch qj=5 while cdb_lbuffer en dest=5 value=0x40 -> entry issues with vj=0x40 and no further CDB.
REQ-032 SHALL cover full/wrap: DEPTH=16, 16 dispatches without issue -> count=16, instqueue_rdy_out=0, 17th ignored; drain and refill 5 -> tail wraps and FIFO order is kept.
REQ-033 SHALL cover flush and reset: 6 entries, rob_flush_in with dispatcher_en_in -> count=0 and no enables; rst_in low mid-issue -> enables 0 without a clock.
REQ-034 SHALL cover stall: lbuffer_rdy_in=0 with load at head and a reported store behind -> no issue; head not bypassed.

Source files
------------

// File: rtl/lsq_param.sv
// Parameterised load/store queue: in-order address issue with CDB wakeup,
// dispatch bypass and one store-data report to the ROB per cycle.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef LB
`define LB  6'd1
`endif
`ifndef LH
`define LH  6'd2
`endif
`ifndef LW
`define LW  6'd3
`endif
`ifndef LBU
`define LBU 6'd4
`endif
`ifndef LHU
`define LHU 6'd5
`endif
`ifndef SB
`define SB  6'd6
`endif
`ifndef SH
`define SH  6'd7
`endif
`ifndef SW
`define SW  6'd8
`endif

module lsq_param #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ROB_W      = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RDY_MARGIN = 1
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        lbuffer_rdy_in,
    output logic                        instqueue_rdy_out,
    input  logic                        dispatcher_en_in,
    input  logic [DATA_W-1:0]           dispatcher_vj_in,
    input  logic [DATA_W-1:0]           dispatcher_vk_in,
    input  logic [ROB_W-1:0]            dispatcher_qj_in,
    input  logic [ROB_W-1:0]            dispatcher_qk_in,
    input  logic [`INST_TYPE_WIDTH-1:0] dispatcher_inst_type_in,
    input  logic [DATA_W-1:0]           dispatcher_A_in,
    input  logic [ROB_W-1:0]            dispatcher_dest_in,
    input  logic                        cdb_alu_en_in,
    input  logic [ROB_W-1:0]            cdb_alu_dest_in,
    input  logic [DATA_W-1:0]           cdb_alu_value_in,
    input  logic                        cdb_lbuffer_en_in,
    input  logic [ROB_W-1:0]            cdb_lbuffer_dest_in,
    input  logic [DATA_W-1:0]           cdb_lbuffer_value_in,
    input  logic                        rob_flush_in,
    output logic                        rob_en_out,
    output logic [ROB_W-1:0]            rob_dest_out,
    output logic [DATA_W-1:0]           rob_value_out,
    output logic                        addressUnit_en_out,
    output logic [DATA_W-1:0]           addressUnit_A_out,
    output logic [DATA_W-1:0]           addressUnit_vj_out,
    output logic [ROB_W-1:0]            addressUnit_dest_out,
    output logic [`INST_TYPE_WIDTH-1:0] addressUnit_inst_type_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IT_W  = `INST_TYPE_WIDTH;

    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  reported;
    logic [IT_W-1:0]   itype [DEPTH];
    logic [DATA_W-1:0] vj    [DEPTH];
    logic [DATA_W-1:0] vk    [DEPTH];
    logic [ROB_W-1:0]  qj    [DEPTH];
    logic [ROB_W-1:0]  qk    [DEPTH];
    logic [DATA_W-1:0] addr  [DEPTH];
    logic [ROB_W-1:0]  dest  [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    function automatic logic is_load(input logic [IT_W-1:0] t);
        return (t >= `LB) && (t <= `LHU);
    endfunction

    function automatic logic is_store(input logic [IT_W-1:0] t);
        return (t >= `SB) && (t <= `SW);
    endfunction

    assign instqueue_rdy_out = (32'(count) + RDY_MARGIN) <= (DEPTH - 1);

    logic issue;
    logic dispatch_ok;

    // Head issue is decided purely from registered entry state.
    always_comb begin
        issue = 1'b0;
        if (count != '0 && valid[head] && qj[head] == '0) begin
            issue = (is_load(itype[head]) && lbuffer_rdy_in) ||
                    (is_store(itype[head]) && reported[head]);
        end
        dispatch_ok = dispatcher_en_in && (count < CNT_W'(DEPTH));
    end

    // Oldest ready, unreported store, scanning forward from head.
    logic              rep_found;
    logic [PTR_W-1:0]  rep_idx;
    logic [DATA_W-1:0] rep_value;

    always_comb begin
        rep_found = 1'b0;
        rep_idx   = '0;
        rep_value = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            automatic logic [PTR_W-1:0] idx = head + PTR_W'(i);
            if (!rep_found && valid[idx] && is_store(itype[idx]) &&
                qk[idx] == '0 && !reported[idx]) begin
                rep_found = 1'b1;
                rep_idx   = idx;
            end
        end
        case (itype[rep_idx])
            `SB:     rep_value = DATA_W'(vk[rep_idx][7:0]);
            `SH:     rep_value = DATA_W'(vk[rep_idx][15:0]);
            default: rep_value = vk[rep_idx];
        endcase
    end

    // Dispatch operands with same-cycle CDB capture; load buffer wins ties.
    logic [DATA_W-1:0] new_vj, new_vk;
    logic [ROB_W-1:0]  new_qj, new_qk;

    always_comb begin
        new_vj = dispatcher_vj_in;
        new_qj = dispatcher_qj_in;
        new_vk = dispatcher_vk_in;
        new_qk = dispatcher_qk_in;
        if (dispatcher_qj_in != '0) begin
            if (cdb_lbuffer_en_in && cdb_lbuffer_dest_in == dispatcher_qj_in) begin
                new_vj = cdb_lbuffer_value_in;
                new_qj = '0;
            end else if (cdb_alu_en_in && cdb_alu_dest_in == dispatcher_qj_in) begin
                new_vj = cdb_alu_value_in;
                new_qj = '0;
            end
        end
        if (dispatcher_qk_in != '0) begin
            if (cdb_lbuffer_en_in && cdb_lbuffer_dest_in == dispatcher_qk_in) begin
                new_vk = cdb_lbuffer_value_in;
                new_qk = '0;
            end else if (cdb_alu_en_in && cdb_alu_dest_in == dispatcher_qk_in) begin
                new_vk = cdb_alu_value_in;
                new_qk = '0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid                     <= '0;
            reported                  <= '0;
            head                      <= '0;
            tail                      <= '0;
            count                     <= '0;
            rob_en_out                <= 1'b0;
            rob_dest_out              <= '0;
            rob_value_out             <= '0;
            addressUnit_en_out        <= 1'b0;
            addressUnit_A_out         <= '0;
            addressUnit_vj_out        <= '0;
            addressUnit_dest_out      <= '0;
            addressUnit_inst_type_out <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                itype[i] <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
                addr[i]  <= '0;
                dest[i]  <= '0;
            end
        end else begin
            rob_en_out         <= 1'b0;
            addressUnit_en_out <= 1'b0;
            if (rdy_in) begin
                if (rob_flush_in) begin
                    valid    <= '0;
                    reported <= '0;
                    head     <= '0;
                    tail     <= '0;
                    count    <= '0;
                end else begin
                    // CDB wakeup of waiting operands.
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (valid[i] && qj[i] != '0) begin
                            if (cdb_lbuffer_en_in && cdb_lbuffer_dest_in == qj[i]) begin
                                vj[i] <= cdb_lbuffer_value_in;
                                qj[i] <= '0;
                            end else if (cdb_alu_en_in && cdb_alu_dest_in == qj[i]) begin
                                vj[i] <= cdb_alu_value_in;
                                qj[i] <= '0;
                            end
                        end
                        if (valid[i] && qk[i] != '0) begin
                            if (cdb_lbuffer_en_in && cdb_lbuffer_dest_in == qk[i]) begin
                                vk[i] <= cdb_lbuffer_value_in;
                                qk[i] <= '0;
                            end else if (cdb_alu_en_in && cdb_alu_dest_in == qk[i]) begin
                                vk[i] <= cdb_alu_value_in;
                                qk[i] <= '0;
                            end
                        end
                    end

                    if (rep_found) begin
                        rob_en_out        <= 1'b1;
                        rob_dest_out      <= dest[rep_idx];
                        rob_value_out     <= rep_value;
                        reported[rep_idx] <= 1'b1;
                    end

                    if (issue) begin
                        addressUnit_en_out        <= 1'b1;
                        addressUnit_A_out         <= addr[head];
                        addressUnit_vj_out        <= vj[head];
                        addressUnit_dest_out      <= dest[head];
                        addressUnit_inst_type_out <= itype[head];
                        valid[head]               <= 1'b0;
                        head                      <= head + PTR_W'(1);
                    end

                    // Tail slot is always free here, so it never collides with the issued head.
                    if (dispatch_ok) begin
                        valid[tail]    <= 1'b1;
                        reported[tail] <= 1'b0;
                        itype[tail]    <= dispatcher_inst_type_in;
                        vj[tail]       <= new_vj;
                        vk[tail]       <= new_vk;
                        qj[tail]       <= new_qj;
                        qk[tail]       <= new_qk;
                        addr[tail]     <= dispatcher_A_in;
                        dest[tail]     <= dispatcher_dest_in;
                        tail           <= tail + PTR_W'(1);
                    end

                    count <= count + CNT_W'(dispatch_ok) - CNT_W'(issue);
                end
            end
        end
    end

endmodule
